// File: rtl/unified_cache_bank_bypass_arb.sv
// Cache-off bypass bank: round-robin / critical-first arbiter onto one registered miss channel,
// outstanding-miss limiter and a 2-entry return FIFO.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif

module unified_cache_bank_bypass_arb #(
    parameter int unsigned NUM_INPUT_PORT       = 4,
    parameter int unsigned PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int unsigned MAX_OUTSTANDING      = 4,
    parameter int unsigned AGE_LIMIT            = 8,
    parameter int unsigned BANK_NUM             = 0
) (
    input  logic                                           clk_in,
    input  logic                                           reset_in,
    input  logic [NUM_INPUT_PORT*PACKET_WIDTH_IN_BITS-1:0] input_request_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]                      input_request_valid_flatted_in,
    input  logic [NUM_INPUT_PORT-1:0]                      input_request_critical_flatted_in,
    output logic [NUM_INPUT_PORT-1:0]                      input_request_ack_out,
    input  logic [PACKET_WIDTH_IN_BITS-1:0]                fetched_request_in,
    input  logic                                           fetched_request_valid_in,
    output logic                                           fetch_ack_out,
    output logic [PACKET_WIDTH_IN_BITS-1:0]                miss_request_out,
    output logic                                           miss_request_valid_out,
    output logic                                           miss_request_critical_out,
    input  logic                                           miss_request_ack_in,
    output logic [PACKET_WIDTH_IN_BITS-1:0]                writeback_request_out,
    output logic                                           writeback_request_valid_out,
    output logic                                           writeback_request_critical_out,
    input  logic                                           writeback_request_ack_in,
    output logic [PACKET_WIDTH_IN_BITS-1:0]                return_request_out,
    output logic                                           return_request_valid_out,
    output logic                                           return_request_critical_out,
    input  logic                                           return_request_ack_in,
    output logic                                           error_unexpected_fetch_out
);

    localparam int unsigned W    = PACKET_WIDTH_IN_BITS;
    localparam int unsigned N    = NUM_INPUT_PORT;
    localparam int unsigned PtrW = $clog2(N);
    localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AgeW-1:0] age_q [N];
    logic [AgeW-1:0] age_d [N];
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            err_q, err_d;

    logic [W-1:0]    miss_pkt_q, miss_pkt_d;
    logic            miss_valid_q, miss_valid_d;
    logic            miss_crit_q, miss_crit_d;

    logic [W-1:0]    fifo_mem_q [2];
    logic            fifo_wr_q, fifo_rd_q;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [N-1:0]    eff_crit, cand, grant;
    logic [PtrW-1:0] grant_idx;
    logic            grant_any, grant_en, slot_free, found;
    logic [W-1:0]    grant_pkt;
    logic            grant_crit;
    logic            fetch_xfer, ret_xfer;

    // Writeback ack and bank id have no function in the bypass bank.
    logic unused_sig;
    assign unused_sig = ^{writeback_request_ack_in, 32'(BANK_NUM)};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eff_crit[i] = input_request_critical_flatted_in[i] || (age_q[i] == AgeW'(AGE_LIMIT));
        end
    end

    assign slot_free = !miss_valid_q || miss_request_ack_in;
    assign grant_en  = reset_in && slot_free && (out_cnt_q < CntW'(MAX_OUTSTANDING));

    always_comb begin
        cand = input_request_valid_flatted_in;
        if (|(input_request_valid_flatted_in & eff_crit)) begin
            cand = input_request_valid_flatted_in & eff_crit;
        end
    end

    // Round-robin search starting at rr_ptr, first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && grant_en && cand[(int'(rr_ptr_q) + k) % N]) begin
                found                             = 1'b1;
                grant[(int'(rr_ptr_q) + k) % N]   = 1'b1;
                grant_idx                         = PtrW'((int'(rr_ptr_q) + k) % N);
            end
        end
    end

    assign grant_any = |grant;

    always_comb begin
        grant_pkt = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_pkt = input_request_flatted_in[i*W +: W];
            end
        end
    end

    assign grant_crit = |(grant & eff_crit);

    assign fetch_ack_out = reset_in && (fifo_cnt_q != 2'd2);
    assign fetch_xfer    = fetched_request_valid_in && fetch_ack_out;
    assign ret_xfer      = (fifo_cnt_q != 2'd0) && return_request_ack_in;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        miss_pkt_d   = miss_pkt_q;
        miss_valid_d = miss_valid_q;
        miss_crit_d  = miss_crit_q;
        if (grant_any) begin
            miss_pkt_d   = grant_pkt;
            miss_valid_d = 1'b1;
            miss_crit_d  = grant_crit;
            rr_ptr_d     = (grant_idx == PtrW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end else if (miss_request_ack_in) begin
            miss_valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (!input_request_valid_flatted_in[i] || grant[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] < AgeW'(AGE_LIMIT)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // A fetch with nothing outstanding is still accepted; it only raises the sticky error.
    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q || (fetch_xfer && (out_cnt_q == '0));
        if (grant_any && !fetch_xfer) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!grant_any && fetch_xfer && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fetch_xfer && !ret_xfer) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (!fetch_xfer && ret_xfer) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr_q      <= '0;
            out_cnt_q     <= '0;
            err_q         <= 1'b0;
            miss_pkt_q    <= '0;
            miss_valid_q  <= 1'b0;
            miss_crit_q   <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_cnt_q    <= out_cnt_d;
            err_q        <= err_d;
            miss_pkt_q   <= miss_pkt_d;
            miss_valid_q <= miss_valid_d;
            miss_crit_q  <= miss_crit_d;
            fifo_cnt_q   <= fifo_cnt_d;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
            if (fetch_xfer) begin
                fifo_mem_q[fifo_wr_q] <= fetched_request_in;
                fifo_wr_q             <= !fifo_wr_q;
            end
            if (ret_xfer) begin
                fifo_rd_q <= !fifo_rd_q;
            end
        end
    end

    assign input_request_ack_out          = grant;
    assign miss_request_out               = miss_pkt_q;
    assign miss_request_valid_out         = miss_valid_q;
    assign miss_request_critical_out      = miss_crit_q;
    assign writeback_request_out          = '0;
    assign writeback_request_valid_out    = 1'b0;
    assign writeback_request_critical_out = 1'b0;
    assign return_request_out             = fifo_mem_q[fifo_rd_q];
    assign return_request_valid_out       = (fifo_cnt_q != 2'd0);
    assign return_request_critical_out    = 1'b1;
    assign error_unexpected_fetch_out     = err_q;

endmodule

// File: tb/tb_unified_cache_bank_bypass_arb.sv
// Directed, table-driven bench for the bypass bank arbiter (4 ports, 16-bit packets).

module tb_unified_cache_bank_bypass_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  crit;
        logic        mack;
        logic        fvalid;
        logic [15:0] fdata;
        logic        rack;
        logic [3:0]  e_ack;
        logic        e_mvalid;
        logic [15:0] e_mpkt;
        logic        e_mcrit;
        logic        e_fack;
        logic        e_rvalid;
        logic [15:0] e_rpkt;
        logic        e_err;
    } vec_t;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [N*W-1:0]  req_flat;
    logic [N-1:0]    req_valid, req_crit, in_ack;
    logic [W-1:0]    fetch_data;
    logic            fetch_valid, fetch_ack;
    logic [W-1:0]    miss_pkt;
    logic            miss_valid, miss_crit, miss_ack;
    logic [W-1:0]    wb_pkt;
    logic            wb_valid, wb_crit;
    logic [W-1:0]    ret_pkt;
    logic            ret_valid, ret_crit, ret_ack;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;
    int got;
    vec_t tab_a[$];
    vec_t tab_d[$];

    always #5 clk_in = ~clk_in;

    unified_cache_bank_bypass_arb #(
        .NUM_INPUT_PORT      (N),
        .PACKET_WIDTH_IN_BITS(W),
        .MAX_OUTSTANDING     (4),
        .AGE_LIMIT           (8),
        .BANK_NUM            (0)
    ) dut (
        .clk_in                           (clk_in),
        .reset_in                         (reset_in),
        .input_request_flatted_in         (req_flat),
        .input_request_valid_flatted_in   (req_valid),
        .input_request_critical_flatted_in(req_crit),
        .input_request_ack_out            (in_ack),
        .fetched_request_in               (fetch_data),
        .fetched_request_valid_in         (fetch_valid),
        .fetch_ack_out                    (fetch_ack),
        .miss_request_out                 (miss_pkt),
        .miss_request_valid_out           (miss_valid),
        .miss_request_critical_out        (miss_crit),
        .miss_request_ack_in              (miss_ack),
        .writeback_request_out            (wb_pkt),
        .writeback_request_valid_out      (wb_valid),
        .writeback_request_critical_out   (wb_crit),
        .writeback_request_ack_in         (1'b1),
        .return_request_out               (ret_pkt),
        .return_request_valid_out         (ret_valid),
        .return_request_critical_out      (ret_crit),
        .return_request_ack_in            (ret_ack),
        .error_unexpected_fetch_out       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] c, input logic ma,
                         input logic fv, input logic [15:0] fd, input logic ra);
        req_valid   = v;
        req_crit    = c;
        miss_ack    = ma;
        fetch_valid = fv;
        fetch_data  = fd;
        ret_ack     = ra;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] c, input logic ma,
                                input logic fv, input logic [15:0] fd, input logic ra,
                                input logic [3:0] ea, input logic emv, input logic [15:0] emp,
                                input logic emc, input logic efa, input logic erv,
                                input logic [15:0] erp, input logic ee);
        vec_t t;
        t.valid = v;  t.crit = c;  t.mack = ma;  t.fvalid = fv;  t.fdata = fd;  t.rack = ra;
        t.e_ack = ea; t.e_mvalid = emv; t.e_mpkt = emp; t.e_mcrit = emc;
        t.e_fack = efa; t.e_rvalid = erv; t.e_rpkt = erp; t.e_err = ee;
        return t;
    endfunction

    task automatic run_table(input vec_t tab[$], input string tag);
        foreach (tab[i]) begin
            drive(tab[i].valid, tab[i].crit, tab[i].mack, tab[i].fvalid, tab[i].fdata,
                  tab[i].rack);
            @(negedge clk_in);
            check($sformatf("%s[%0d].ack", tag, i), 32'(in_ack), 32'(tab[i].e_ack));
            check($sformatf("%s[%0d].miss_valid", tag, i), 32'(miss_valid), 32'(tab[i].e_mvalid));
            if (tab[i].e_mvalid) begin
                check($sformatf("%s[%0d].miss_pkt", tag, i), 32'(miss_pkt), 32'(tab[i].e_mpkt));
                check($sformatf("%s[%0d].miss_crit", tag, i), 32'(miss_crit),
                      32'(tab[i].e_mcrit));
            end
            check($sformatf("%s[%0d].fetch_ack", tag, i), 32'(fetch_ack), 32'(tab[i].e_fack));
            check($sformatf("%s[%0d].ret_valid", tag, i), 32'(ret_valid), 32'(tab[i].e_rvalid));
            if (tab[i].e_rvalid) begin
                check($sformatf("%s[%0d].ret_pkt", tag, i), 32'(ret_pkt), 32'(tab[i].e_rpkt));
            end
            check($sformatf("%s[%0d].err", tag, i), 32'(err), 32'(tab[i].e_err));
            next_cycle();
        end
    endtask

    initial begin
        // Round-robin fill to the outstanding limit, release one slot, then drain.
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b0001, 0, 0,       0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b0010, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b0100, 1, 16'hA001, 0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b1000, 1, 16'hA002, 0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b0000, 1, 16'hA003, 0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 1, 16'h00F1, 1, 4'b0000, 0, 0,       0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'hF, 0, 1, 0, 0,       1, 4'b0001, 0, 0,       0, 1, 1, 16'h00F1, 0));
        tab_a.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'h0, 0, 1, 1, 16'h00F2, 1, 4'b0000, 0, 0,       0, 1, 0, 0,       0));
        tab_a.push_back(mk(4'h0, 0, 1, 1, 16'h00F3, 1, 4'b0000, 0, 0,       0, 1, 1, 16'h00F2, 0));
        tab_a.push_back(mk(4'h0, 0, 1, 1, 16'h00F4, 1, 4'b0000, 0, 0,       0, 1, 1, 16'h00F3, 0));
        tab_a.push_back(mk(4'h0, 0, 1, 1, 16'h00F5, 1, 4'b0000, 0, 0,       0, 1, 1, 16'h00F4, 0));
        tab_a.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 0, 0,       0, 1, 1, 16'h00F5, 0));

        // Miss hold under backpressure, return FIFO full/ordering, unexpected fetch.
        tab_d.push_back(mk(4'h1, 0, 0, 0, 0,       1, 4'b0001, 0, 0,       0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h1, 0, 0, 0, 0,       1, 4'b0000, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h1, 0, 1, 0, 0,       1, 4'b0001, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h1, 0, 1, 0, 0,       1, 4'b0001, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 1, 16'hA000, 0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hD001, 0, 4'b0000, 0, 0,       0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hD002, 0, 4'b0000, 0, 0,       0, 1, 1, 16'hD001, 0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hD003, 0, 4'b0000, 0, 0,       0, 0, 1, 16'hD001, 0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hD003, 1, 4'b0000, 0, 0,       0, 0, 1, 16'hD001, 0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hD003, 1, 4'b0000, 0, 0,       0, 1, 1, 16'hD002, 0));
        tab_d.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 0, 0,       0, 1, 1, 16'hD003, 0));
        tab_d.push_back(mk(4'h0, 0, 1, 1, 16'hE001, 1, 4'b0000, 0, 0,       0, 1, 0, 0,       0));
        tab_d.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 0, 0,       0, 1, 1, 16'hE001, 1));
        tab_d.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 0, 0,       0, 1, 0, 0,       1));
        tab_d.push_back(mk(4'h0, 0, 1, 0, 0,       1, 4'b0000, 0, 0,       0, 1, 0, 0,       1));

        req_flat = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        reset_in = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst.ack", 32'(in_ack), 0);
        check("rst.miss_valid", 32'(miss_valid), 0);
        check("rst.ret_valid", 32'(ret_valid), 0);
        check("rst.fetch_ack", 32'(fetch_ack), 0);
        check("rst.err", 32'(err), 0);
        check("rst.wb", 32'({wb_valid, wb_crit, wb_pkt}), 0);
        check("rst.ret_crit", 32'(ret_crit), 1);
        next_cycle();
        reset_in = 1'b1;
        #1;
        check("rst.fetch_ack_after", 32'(fetch_ack), 1);

        run_table(tab_a, "rr");

        // Critical port beats round-robin order.
        drive(4'b0101, 4'b0100, 1, 0, 0, 1);
        @(negedge clk_in);
        check("crit.first_ack", 32'(in_ack), 32'b0100);
        next_cycle();
        drive(4'b0001, 4'b0000, 1, 0, 0, 1);
        @(negedge clk_in);
        check("crit.second_ack", 32'(in_ack), 32'b0001);
        check("crit.miss_pkt", 32'(miss_pkt), 32'hA002);
        check("crit.miss_crit", 32'(miss_crit), 1);
        next_cycle();
        drive(4'b0000, 4'b0000, 1, 0, 0, 1);
        @(negedge clk_in);
        check("crit.miss2_pkt", 32'(miss_pkt), 32'hA000);
        check("crit.miss2_crit", 32'(miss_crit), 0);
        next_cycle();
        drive(4'b0000, 4'b0000, 1, 1, 16'hB001, 1);
        next_cycle();
        drive(4'b0000, 4'b0000, 1, 1, 16'hB002, 1);
        @(negedge clk_in);
        check("crit.ret1", 32'(ret_pkt), 32'hB001);
        next_cycle();
        drive(4'b0000, 4'b0000, 1, 0, 0, 1);
        @(negedge clk_in);
        check("crit.ret2", 32'(ret_pkt), 32'hB002);
        next_cycle();

        // Ports 0/3 critical and always requesting; port 1 must be promoted by age.
        got = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(4'b1011, 4'b1001, 1, (k >= 2), 16'(16'hC000 + k), 1);
            @(negedge clk_in);
            check("age.ack_legal", 32'(((in_ack & ~4'b1011) == 4'b0) && $onehot0(in_ack)), 1);
            if (in_ack[1]) got = k;
            next_cycle();
            if (got != 0) break;
        end
        check("age.granted_by_9", 32'(got >= 1 && got <= 9), 1);
        drive(4'b0000, 4'b0000, 1, 1, 16'hC0FF, 1);
        @(negedge clk_in);
        check("age.miss_pkt", 32'(miss_pkt), 32'hA001);
        check("age.miss_crit", 32'(miss_crit), 1);
        next_cycle();
        drive(4'b0000, 4'b0000, 1, 0, 0, 1);
        @(negedge clk_in);
        check("age.ret", 32'(ret_pkt), 32'hC0FF);
        next_cycle();

        run_table(tab_d, "fifo");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
